// File: rtl/pci_rr_arbiter.sv
// PCI central arbiter: round-robin over active-low REQ#, registered GNT#,
// one dead clock between grantees, grant timeout, optional parking.
// Ports: i_clk, i_rst_n (async, active-low), i_frame_n, i_irdy_n,
//   i_req_n[NREQ], o_gnt_n[NREQ], o_owner[IDW], o_owner_valid.
// Macro: PCI_ARB_PARK_EN enables bus parking on PARK_ID.
module pci_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int PARK_ID     = 0,
  parameter int GNT_TIMEOUT = 16,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_frame_n,
  input  logic            i_irdy_n,
  input  logic [NREQ-1:0] i_req_n,
  output logic [NREQ-1:0] o_gnt_n,
  output logic [IDW-1:0]  o_owner,
  output logic            o_owner_valid
);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("NREQ must be 2..16");
  end
  if (PARK_ID < 0 || PARK_ID >= NREQ) begin : g_bad_park
    $error("PARK_ID must be < NREQ");
  end
  if (GNT_TIMEOUT < 2 || GNT_TIMEOUT > 255) begin : g_bad_tmo
    $error("GNT_TIMEOUT must be 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_DEAD,
    S_PARK
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(GNT_TIMEOUT - 1);
`ifdef PCI_ARB_PARK_EN
  localparam logic [IDW-1:0] PARK_IDX = IDW'(PARK_ID);
`endif

  state_t            r_state;
  logic [NREQ-1:0]   r_gnt_n;
  logic [IDW-1:0]    r_owner;
  logic [IDW-1:0]    r_last;
  logic [7:0]        r_tmo;

  state_t            w_nstate;
  logic [NREQ-1:0]   w_ngnt;
  logic [IDW-1:0]    w_nowner;
  logic [IDW-1:0]    w_nlast;
  logic [7:0]        w_ntmo;

  logic [NREQ-1:0]   w_req;
  logic [NREQ-1:0]   w_own_mask;
  logic              w_any;
  logic              w_own_req;
  logic              w_others;
  logic              w_bus_idle;
  logic              w_found;
  logic [IDW-1:0]    w_sel;

  assign w_req      = ~i_req_n;
  assign w_own_mask = NREQ'(1) << r_owner;
  assign w_any      = |w_req;
  assign w_own_req  = |(w_req & w_own_mask);
  assign w_others   = |(w_req & ~w_own_mask);
  assign w_bus_idle = i_frame_n & i_irdy_n;

  // First requester after the last grantee, wrapping.
  always_comb begin
    logic [IDW-1:0] v_idx;
    v_idx   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && w_req[v_idx]) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ngnt   = r_gnt_n;
    w_nowner = r_owner;
    w_nlast  = r_last;
    w_ntmo   = '0;
    unique case (r_state)
      S_IDLE, S_DEAD: begin
        if (w_found) begin
          w_nstate = S_GRANT;
          w_ngnt   = ~(NREQ'(1) << w_sel);
          w_nowner = w_sel;
          w_nlast  = w_sel;
        end else if (r_state == S_DEAD) begin
          w_nstate = S_IDLE;
          w_ngnt   = '1;
        end else begin
`ifdef PCI_ARB_PARK_EN
          w_nstate = S_PARK;
          w_ngnt   = ~(NREQ'(1) << PARK_IDX);
          w_nowner = PARK_IDX;
`endif
        end
      end
      S_GRANT: begin
        if (!i_frame_n) begin
          w_nstate = S_BUSY;
        end else if (w_bus_idle &&
                     (!w_own_req || r_tmo == TMO_LAST)) begin
          w_nstate = S_DEAD;
          w_ngnt   = '1;
        end else if (w_bus_idle) begin
          w_ntmo = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;
        end
      end
      S_BUSY: begin
        if (w_others) begin
          w_nstate = S_DEAD;
          w_ngnt   = '1;
        end else if (w_bus_idle) begin
          w_nstate = S_GRANT;
        end
      end
`ifdef PCI_ARB_PARK_EN
      S_PARK: begin
        if (!i_frame_n) begin
          w_nstate = S_BUSY;
          w_nlast  = PARK_IDX;
        end else if (w_own_req) begin
          w_nstate = S_GRANT;
          w_nlast  = PARK_IDX;
        end else if (w_any) begin
          w_nstate = S_DEAD;
          w_ngnt   = '1;
        end
      end
`endif
      default: begin
        w_nstate = S_IDLE;
        w_ngnt   = '1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_gnt_n <= '1;
      r_owner <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_tmo   <= '0;
    end else begin
      r_state <= w_nstate;
      r_gnt_n <= w_ngnt;
      r_owner <= w_nowner;
      r_last  <= w_nlast;
      r_tmo   <= w_ntmo;
    end
  end

  assign o_gnt_n       = r_gnt_n;
  assign o_owner       = r_owner;
  assign o_owner_valid = ~&r_gnt_n;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: directed scenarios plus random
// REQ#/FRAME#/IRDY# against a behavioural model of the arbiter.
module tb_pci_rr_arbiter;
  localparam int N = 4;
  localparam int T = 16;
  localparam int PK = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_n = 1'b1;
  logic       irdy_n = 1'b1;
  logic [3:0] req_n = 4'hF;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       ov;

  logic       f8 = 1'b1;
  logic       i8 = 1'b1;
  logic [7:0] req8 = 8'hFF;
  logic [7:0] gnt8;
  logic [2:0] own8;
  logic       ov8;

  pci_rr_arbiter #(.NREQ(N), .PARK_ID(PK), .GNT_TIMEOUT(T)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_n(frame_n),
    .i_irdy_n(irdy_n), .i_req_n(req_n), .o_gnt_n(gnt_n),
    .o_owner(owner), .o_owner_valid(ov)
  );

  pci_rr_arbiter #(.NREQ(8), .PARK_ID(5), .GNT_TIMEOUT(T)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_n(f8),
    .i_irdy_n(i8), .i_req_n(req8), .o_gnt_n(gnt8),
    .o_owner(own8), .o_owner_valid(ov8)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: who holds GNT#, whether their transaction
  // started, whether a dead clock is pending, idle clocks so far.
  bit m_has, m_txn, m_gap, m_park;
  int m_own, m_last, m_idle;
  logic [3:0] prev;
  int wt [4];

  task automatic m_reset();
    m_has = 0; m_txn = 0; m_gap = 0; m_park = 0;
    m_own = 0; m_last = N - 1; m_idle = 0;
    prev = 4'hF;
    for (int i = 0; i < N; i++) wt[i] = 0;
  endtask

  task automatic m_grant(input logic [3:0] req);
    for (int k = 1; k <= N; k++) begin
      if (!req[(m_last + k) % N]) begin
        m_own = (m_last + k) % N;
        break;
      end
    end
    m_last = m_own;
    m_has = 1; m_txn = 0; m_idle = 0;
  endtask

  task automatic m_drop();
    m_has = 0; m_txn = 0; m_idle = 0; m_gap = 1;
  endtask

  task automatic m_step(input logic [3:0] req, input logic f,
                        input logic ir);
    bit bi, anyr, oth;
    bi = f & ir;
    anyr = (req != 4'hF);
    oth = ((req | (4'b1 << m_own)) != 4'hF);
    if (m_gap) begin
      m_gap = 0;
      if (anyr) m_grant(req);
    end else if (!m_has && !m_park) begin
      if (anyr) m_grant(req);
`ifdef PCI_ARB_PARK_EN
      else begin m_park = 1; m_own = PK; end
`endif
    end else if (m_park) begin
      if (!f) begin
        m_park = 0; m_has = 1; m_txn = 1; m_last = PK;
      end else if (!req[PK]) begin
        m_park = 0; m_has = 1; m_txn = 0; m_idle = 0; m_last = PK;
      end else if (anyr) begin
        m_park = 0; m_gap = 1;
      end
    end else if (!m_txn) begin
      if (!f) begin
        m_txn = 1; m_idle = 0;
      end else if (bi && req[m_own]) begin
        m_drop();
      end else if (bi) begin
        m_idle++;
        if (m_idle >= T) m_drop();
      end else begin
        m_idle = 0;
      end
    end else begin
      if (oth) m_drop();
      else if (bi) begin m_txn = 0; m_idle = 0; end
    end
  endtask

  task automatic check_all();
    int exp;
    exp = (m_has || m_park) ? int'(4'hF ^ (4'b1 << m_own)) : 15;
    chk("gnt", int'(gnt_n), exp);
    chk("owner", int'(owner), m_own);
    chk("valid", int'(ov), int'(m_has || m_park));
    chk("onehot", int'($countones(~gnt_n) <= 1), 1);
    if (prev != 4'hF && gnt_n != 4'hF)
      chk("deadcyc", int'(gnt_n), int'(prev));
    if (gnt_n != 4'hF && gnt_n != prev) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(owner) || req_n[i]) wt[i] = 0;
        else wt[i]++;
        chk("starve", int'(wt[i] <= N), 1);
      end
    end
    prev = gnt_n;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step(req_n, frame_n, irdy_n);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_n = 1'b1; irdy_n = 1'b1; req_n = 4'hF;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    int cnt, w, burst;
    m_reset();

    // Reset state and round-robin order with everyone requesting.
    do_reset();
    chk("rst_gnt", int'(gnt_n), 15);
    chk("rst_valid", int'(ov), 0);
    req_n = 4'h0;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (gnt_n == 4'hF && w < 20) begin cyc(); w++; end
      if (gnt_n == 4'hF) chk("t1_wait", 0, 1);
      chk("t1_owner", int'(owner), g % N);
      chk("t1_gnt", int'(gnt_n), int'(4'hF ^ (4'b1 << (g % N))));
      frame_n = 1'b0; irdy_n = 1'b1; cyc();
      frame_n = 1'b0; irdy_n = 1'b0; cyc();
      frame_n = 1'b1; irdy_n = 1'b0; cyc();
      frame_n = 1'b1; irdy_n = 1'b1;
    end

    // Grant timeout on an idle bus.
    do_reset();
    req_n = 4'b1011;
    cyc();
    cnt = 0; w = 0;
    while (gnt_n == 4'b1011 && w < 40) begin cnt++; cyc(); w++; end
    chk("t2_low", cnt, 16);
    chk("t2_dead", int'(gnt_n), 15);
    cyc();
    chk("t2_regrant", int'(gnt_n), 11);

    // Hidden arbitration while master1 is busy.
    do_reset();
    req_n = 4'b1101;
    cyc();
    frame_n = 1'b0; cyc(); cyc();
    chk("t3_busy", int'(gnt_n), 13);
    req_n = 4'b0111; cyc();
    chk("t3_dead", int'(gnt_n), 15);
    cyc();
    chk("t3_hidden", int'(gnt_n), 7);
    cyc();
    chk("t3_hold", int'(gnt_n), 7);
    frame_n = 1'b1; irdy_n = 1'b1; cyc();
    chk("t3_idle", int'(gnt_n), 7);

    // Asynchronous reset in BUSY.
    do_reset();
    req_n = 4'b1101; cyc();
    frame_n = 1'b0; cyc();
    chk("t4_busy", int'(gnt_n), 13);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rgnt", int'(gnt_n), 15);
    chk("t4_rown", int'(owner), 0);
    chk("t4_rval", int'(ov), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1; frame_n = 1'b1; req_n = 4'b1010;
    cyc();
    chk("t4_first", int'(gnt_n), 14);

    // Wrap-around on the 8-requester instance.
    do_reset();
    req8 = 8'hBF; cyc();
    chk("t5_g6", int'(gnt8), 8'hBF);
    req8 = 8'h7E; cyc();
    chk("t5_dead1", int'(gnt8), 8'hFF);
    cyc();
    chk("t5_g7", int'(gnt8), 8'h7F);
    chk("t5_own7", int'(own8), 7);
    req8 = 8'hFE; cyc();
    chk("t5_dead2", int'(gnt8), 8'hFF);
    cyc();
    chk("t5_g0", int'(gnt8), 8'hFE);
    chk("t5_own0", int'(own8), 0);
    req8 = 8'hFF; cyc(); cyc(); cyc();
`ifdef PCI_ARB_PARK_EN
    chk("t5_park", int'(gnt8), 8'hDF);
    chk("t5_pval", int'(ov8), 1);
`else
    chk("t5_nopark", int'(gnt8), 8'hFF);
    chk("t5_pval", int'(ov8), 0);
`endif

    // Random traffic.
    do_reset();
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0)
        req_n[$urandom_range(3)] = ~req_n[$urandom_range(3)];
      if ($urandom_range(5) == 0)
        req_n[$urandom_range(3)] = 1'b1;
      if (burst > 0) begin
        burst--;
        frame_n = (burst == 0);
        irdy_n = 1'b0;
      end else begin
        frame_n = 1'b1; irdy_n = 1'b1;
        if ($urandom_range(15) == 0) begin
          burst = $urandom_range(4, 1);
          frame_n = 1'b0;
        end
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
